// File: rtl/eth_link_pkg.sv
// rtl/eth_link_pkg.sv - state encoding and counter widths shared by the Ethernet link supervisor
package eth_link_pkg;

  localparam int STATE_W     = 3;
  localparam int RETRY_W     = 4;
  localparam int LINK_DOWN_W = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_GT    = 3'd1,
    ST_WAIT_LOCK  = 3'd2,
    ST_STABILIZE  = 3'd3,
    ST_LINK_UP    = 3'd4,
    ST_RX_RESET   = 3'd5,
    ST_FULL_RESET = 3'd6
  } link_state_e;

endpackage

// File: rtl/eth_link_supervisor_if.sv
// rtl/eth_link_supervisor_if.sv - transceiver status/control bundle; link_down_count_o exists with ETH_LINK_STATS_EN
interface eth_link_supervisor_if;
  import eth_link_pkg::*;

  logic                   enable_i;
  logic                   gt_reset_tx_done_i;
  logic                   gt_reset_rx_done_i;
  logic                   rx_block_lock_i;
  logic                   rx_high_ber_i;
  logic                   rx_datapath_reset_o;
  logic                   reset_all_o;
  logic                   link_up_o;
  logic [STATE_W-1:0]     state_o;
  logic [RETRY_W-1:0]     retry_count_o;
`ifdef ETH_LINK_STATS_EN
  logic [LINK_DOWN_W-1:0] link_down_count_o;
`endif

  // master: transceiver wrapper / port logic side; slave: the supervisor itself
  modport master (
    output enable_i, gt_reset_tx_done_i, gt_reset_rx_done_i, rx_block_lock_i, rx_high_ber_i,
    input  rx_datapath_reset_o, reset_all_o, link_up_o, state_o, retry_count_o
`ifdef ETH_LINK_STATS_EN
    , input link_down_count_o
`endif
  );

  modport slave (
    input  enable_i, gt_reset_tx_done_i, gt_reset_rx_done_i, rx_block_lock_i, rx_high_ber_i,
    output rx_datapath_reset_o, reset_all_o, link_up_o, state_o, retry_count_o
`ifdef ETH_LINK_STATS_EN
    , output link_down_count_o
`endif
  );

endinterface

// File: rtl/eth_link_sync.sv
// rtl/eth_link_sync.sv - parameterized-width 2-flop synchronizer, async reset to 0
module eth_link_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_125mhz_int,
  input  logic             gt_tx_reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/eth_link_supervisor.sv
// rtl/eth_link_supervisor.sv - 10G link bring-up/recovery sequencer; ETH_LINK_STATS_EN adds the link-down counter
module eth_link_supervisor
  import eth_link_pkg::*;
#(
  parameter int LOCK_TIMEOUT_CYCLES = 125000,
  parameter int STABLE_CYCLES       = 12500,
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int MAX_RETRIES         = 8
) (
  input  logic                 clk_125mhz_int,
  input  logic                 gt_tx_reset,
  eth_link_supervisor_if.slave link
);

  localparam int TIMER_SPAN = (LOCK_TIMEOUT_CYCLES > STABLE_CYCLES) ? LOCK_TIMEOUT_CYCLES : STABLE_CYCLES;
  localparam int TIMER_MAX  = (TIMER_SPAN > RESET_PULSE_CYCLES) ? TIMER_SPAN : RESET_PULSE_CYCLES;
  localparam int TIMER_W    = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PULSE_LAST  = TIMER_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES - 1);

  localparam logic [STATE_W-1:0] S_IDLE       = ST_IDLE;
  localparam logic [STATE_W-1:0] S_WAIT_GT    = ST_WAIT_GT;
  localparam logic [STATE_W-1:0] S_WAIT_LOCK  = ST_WAIT_LOCK;
  localparam logic [STATE_W-1:0] S_STABILIZE  = ST_STABILIZE;
  localparam logic [STATE_W-1:0] S_LINK_UP    = ST_LINK_UP;
  localparam logic [STATE_W-1:0] S_RX_RESET   = ST_RX_RESET;
  localparam logic [STATE_W-1:0] S_FULL_RESET = ST_FULL_RESET;

  logic [3:0]         sync_in;
  logic [3:0]         sync_q;
  logic               txd_s;
  logic               rxd_s;
  logic               lock_s;
  logic               ber_s;
  logic               clean;
  logic               enable;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [TIMER_W-1:0] timer;
  logic [RETRY_W-1:0] retry;
  logic               retry_inc;
  logic               retry_clr;

  logic               rx_reset_q;
  logic               reset_all_q;
  logic               link_up_q;
  logic [STATE_W-1:0] state_out_q;

  assign sync_in = {link.rx_high_ber_i, link.rx_block_lock_i,
                    link.gt_reset_rx_done_i, link.gt_reset_tx_done_i};

  eth_link_sync #(.WIDTH(4)) u_sync (
    .clk_125mhz_int (clk_125mhz_int),
    .gt_tx_reset    (gt_tx_reset),
    .d              (sync_in),
    .q              (sync_q)
  );

  assign txd_s  = sync_q[0];
  assign rxd_s  = sync_q[1];
  assign lock_s = sync_q[2];
  assign ber_s  = sync_q[3];
  assign clean  = lock_s & ~ber_s;
  assign enable = link.enable_i;

  // Disable beats every other condition, including a pulse still in progress.
  always_comb begin
    state_next = state;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
    if (!enable) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      state_next = S_WAIT_GT;
        S_WAIT_GT:   if (txd_s && rxd_s) state_next = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_next = S_STABILIZE;
          end else if (timer == LOCK_LAST) begin
            if (retry < RETRY_LIMIT) begin
              state_next = S_RX_RESET;
              retry_inc  = 1'b1;
            end else begin
              state_next = S_FULL_RESET;
              retry_clr  = 1'b1;
            end
          end
        end
        S_STABILIZE: begin
          if (!clean) begin
            state_next = S_WAIT_LOCK;
          end else if (timer == STABLE_LAST) begin
            state_next = S_LINK_UP;
            retry_clr  = 1'b1;
          end
        end
        S_LINK_UP:     if (!clean) state_next = S_RX_RESET;
        S_RX_RESET:    if (timer == PULSE_LAST) state_next = S_WAIT_GT;
        S_FULL_RESET:  if (timer == PULSE_LAST) state_next = S_WAIT_GT;
        default:       state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      state <= S_IDLE;
      timer <= '0;
      retry <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        timer <= '0;
      end else if (timer != '1) begin
        timer <= timer + TIMER_W'(1);
      end
      if (retry_clr) begin
        retry <= '0;
      end else if (retry_inc && retry != '1) begin
        retry <= retry + RETRY_W'(1);
      end
    end
  end

  // Outputs trail the state register by one cycle, except that disable clears them immediately.
  always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      rx_reset_q  <= 1'b0;
      reset_all_q <= 1'b0;
      link_up_q   <= 1'b0;
      state_out_q <= S_IDLE;
    end else begin
      rx_reset_q  <= enable && (state == S_RX_RESET);
      reset_all_q <= enable && (state == S_FULL_RESET);
      link_up_q   <= enable && (state == S_LINK_UP);
      state_out_q <= enable ? state : S_IDLE;
    end
  end

  assign link.rx_datapath_reset_o = rx_reset_q;
  assign link.reset_all_o         = reset_all_q;
  assign link.link_up_o           = link_up_q;
  assign link.state_o             = state_out_q;
  assign link.retry_count_o       = retry;

`ifdef ETH_LINK_STATS_EN
  logic [LINK_DOWN_W-1:0] link_down;
  logic                   link_down_inc;

  assign link_down_inc = enable && (state == S_LINK_UP) && !clean;

  always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      link_down <= '0;
    end else if (link_down_inc && link_down != '1) begin
      link_down <= link_down + LINK_DOWN_W'(1);
    end
  end

  assign link.link_down_count_o = link_down;
`endif

endmodule
